// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART definitions: receiver FSM state encoding,
//                default oversampling ratio and the baud-generator constants.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Baud-rate generator operating point (50 MHz system clock, 115200 baud)
    localparam int unsigned c_CLK_FREQ_HZ = 50000000;
    localparam int unsigned c_BAUD_RATE   = 115200;

    // rxclk_en ticks per bit period
    localparam int unsigned c_OVERSAMPLE_DEFAULT = 16;

    // Receiver FSM state encoding
    localparam logic [2:0] c_ST_IDLE      = 3'd0;
    localparam logic [2:0] c_ST_START     = 3'd1;
    localparam logic [2:0] c_ST_DATA      = 3'd2;
    localparam logic [2:0] c_ST_PARITY    = 3'd3;
    localparam logic [2:0] c_ST_STOP      = 3'd4;
    localparam logic [2:0] c_ST_WAIT_IDLE = 3'd5;

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module      : sync_2ff
//  Description : Generic two-flop synchronizer for a single-bit asynchronous
//                input. Both flops take RESET_VALUE during reset so the
//                output shows a known line level from the first cycle.
//  Ports       : clk      - destination clock
//                reset_n  - asynchronous active-low reset
//                i_d      - asynchronous input
//                o_q      - synchronized output (2-cycle latency)
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_meta <= RESET_VALUE;
            r_sync <= RESET_VALUE;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/uart_rx_os16.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_os16
//  Description : 8N1 UART receiver using a 16x oversampling enable. Each
//                received byte is presented on data with a sticky rdy flag
//                that the consumer clears with rdy_clr.
//  Ports       : clk_50m    - system clock
//                reset_n    - asynchronous active-low reset
//                rxclk_en   - oversampling enable, OVERSAMPLE per bit
//                rx         - asynchronous serial input, idles high
//                rdy_clr    - clears rdy, overrun and frame_err
//                data       - last good received byte
//                rdy        - sticky, new byte available
//                overrun    - sticky, byte completed while rdy was set
//                frame_err  - sticky, stop bit sampled low
//                parity_err - sticky, even-parity mismatch
//  Config      : define UART_RX_PARITY_EN to add an even-parity bit after
//                the data bits; otherwise parity_err is tied low.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_os16
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned OVERSAMPLE = c_OVERSAMPLE_DEFAULT
) (
    input  logic                 clk_50m,
    input  logic                 reset_n,
    input  logic                 rxclk_en,
    input  logic                 rx,
    input  logic                 rdy_clr,
    output logic [DATA_BITS-1:0] data,
    output logic                 rdy,
    output logic                 overrun,
    output logic                 frame_err,
    output logic                 parity_err
);

    localparam int unsigned c_SW = $clog2(OVERSAMPLE);
    localparam int unsigned c_BW = $clog2(DATA_BITS + 1);

    localparam logic [c_SW-1:0] c_SAMPLE_MID  = c_SW'(OVERSAMPLE / 2 - 1);
    localparam logic [c_SW-1:0] c_SAMPLE_LAST = c_SW'(OVERSAMPLE - 1);
    localparam logic [c_BW-1:0] c_BIT_LAST    = c_BW'(DATA_BITS - 1);

`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] c_ST_AFTER_DATA = c_ST_PARITY;
`else
    localparam logic [2:0] c_ST_AFTER_DATA = c_ST_STOP;
`endif

    logic                 w_rx;
    logic [2:0]           r_state;
    logic [c_SW-1:0]      r_sample;
    logic [c_BW-1:0]      r_bit;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_rdy;
    logic                 r_overrun;
    logic                 r_frame_err;
    logic                 w_sample_last;
    logic                 w_stop_good;
    logic                 w_stop_bad;

    sync_2ff #(
        .RESET_VALUE (1'b1)
    ) u_rx_sync (
        .clk     (clk_50m),
        .reset_n (reset_n),
        .i_d     (rx),
        .o_q     (w_rx)
    );

    // Stop-bit decision strobes, used by the flag registers below
    always_comb begin
        w_sample_last = rxclk_en && (r_sample == c_SAMPLE_LAST);
        w_stop_good   = w_sample_last && (r_state == c_ST_STOP) && w_rx;
        w_stop_bad    = w_sample_last && (r_state == c_ST_STOP) && !w_rx;
    end

`ifdef UART_RX_PARITY_EN
    logic r_par_bad;
    logic r_parity_err;
`endif

    // ------------------------------------------------------------------
    // Frame FSM: advances only on oversampling ticks
    // ------------------------------------------------------------------
    always_ff @(posedge clk_50m or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= c_ST_IDLE;
            r_sample <= '0;
            r_bit    <= '0;
            r_shift  <= '0;
`ifdef UART_RX_PARITY_EN
            r_par_bad <= 1'b0;
`endif
        end else if (rxclk_en) begin
            case (r_state)
                c_ST_IDLE: begin
                    if (!w_rx) begin
                        r_state  <= c_ST_START;
                        r_sample <= '0;
                    end
                end
                c_ST_START: begin
                    // Re-check the line at the centre of the start bit to
                    // reject glitches shorter than half a bit.
                    if (r_sample == c_SAMPLE_MID) begin
                        if (w_rx) begin
                            r_state <= c_ST_IDLE;
                        end else begin
                            r_state  <= c_ST_DATA;
                            r_sample <= '0;
                            r_bit    <= '0;
                        end
                    end else begin
                        r_sample <= r_sample + 1'b1;
                    end
                end
                c_ST_DATA: begin
                    // Counting a full bit from mid start bit lands mid data bit
                    if (r_sample == c_SAMPLE_LAST) begin
                        r_shift  <= {w_rx, r_shift[DATA_BITS-1:1]};
                        r_sample <= '0;
                        r_bit    <= r_bit + 1'b1;
                        if (r_bit == c_BIT_LAST) begin
                            r_state <= c_ST_AFTER_DATA;
                        end
                    end else begin
                        r_sample <= r_sample + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                c_ST_PARITY: begin
                    if (r_sample == c_SAMPLE_LAST) begin
                        // Even parity: data bits plus parity bit hold an even
                        // number of ones, so a non-zero XOR is a mismatch.
                        r_par_bad <= w_rx ^ (^r_shift);
                        r_sample  <= '0;
                        r_state   <= c_ST_STOP;
                    end else begin
                        r_sample <= r_sample + 1'b1;
                    end
                end
`endif
                c_ST_STOP: begin
                    if (r_sample == c_SAMPLE_LAST) begin
                        r_sample <= '0;
                        r_state  <= w_rx ? c_ST_IDLE : c_ST_WAIT_IDLE;
                    end else begin
                        r_sample <= r_sample + 1'b1;
                    end
                end
                c_ST_WAIT_IDLE: begin
                    // Hold off new starts until a break condition ends
                    if (w_rx) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output byte and sticky flags. A set in the same cycle as rdy_clr
    // wins, so a byte completing during a clear is never lost.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_50m or negedge reset_n) begin
        if (!reset_n) begin
            r_data      <= '0;
            r_rdy       <= 1'b0;
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_stop_good) begin
                r_data <= r_shift;
            end

            if (w_stop_good) begin
                r_rdy <= 1'b1;
            end else if (rdy_clr) begin
                r_rdy <= 1'b0;
            end

            if (w_stop_good && r_rdy) begin
                r_overrun <= 1'b1;
            end else if (rdy_clr) begin
                r_overrun <= 1'b0;
            end

            if (w_stop_bad) begin
                r_frame_err <= 1'b1;
            end else if (rdy_clr) begin
                r_frame_err <= 1'b0;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    // Parity error is only cleared by reset; rdy_clr does not touch it
    always_ff @(posedge clk_50m or negedge reset_n) begin
        if (!reset_n) begin
            r_parity_err <= 1'b0;
        end else if ((w_stop_good || w_stop_bad) && r_par_bad) begin
            r_parity_err <= 1'b1;
        end
    end

    assign parity_err = r_parity_err;
`else
    assign parity_err = 1'b0;
`endif

    assign data      = r_data;
    assign rdy       = r_rdy;
    assign overrun   = r_overrun;
    assign frame_err = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_os16.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_os16
//  Description : Self-checking bench for uart_rx_os16. rxclk_en pulses every
//                4 clocks, so one bit lasts 64 clocks. A vector table covers
//                plain receive and overrun; hand-written sequences cover
//                latency, start glitch, break/framing error, mid-frame reset,
//                set-vs-clear priority and (with UART_RX_PARITY_EN) parity.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_os16;

    localparam int c_BIT_CYC = 64;
`ifdef UART_RX_PARITY_EN
    localparam int c_LAT_MIN = 600 + 64;
    localparam int c_LAT_MAX = 625 + 64;
`else
    localparam int c_LAT_MIN = 600;
    localparam int c_LAT_MAX = 625;
`endif

    logic       clk_50m;
    logic       reset_n;
    logic       rxclk_en;
    logic       rx;
    logic       rdy_clr;
    logic [7:0] data;
    logic       rdy;
    logic       overrun;
    logic       frame_err;
    logic       parity_err;

    int n_checks;
    int n_errors;
    int tick_cnt;

    uart_rx_os16 #(
        .DATA_BITS  (8),
        .OVERSAMPLE (16)
    ) dut (
        .clk_50m    (clk_50m),
        .reset_n    (reset_n),
        .rxclk_en   (rxclk_en),
        .rx         (rx),
        .rdy_clr    (rdy_clr),
        .data       (data),
        .rdy        (rdy),
        .overrun    (overrun),
        .frame_err  (frame_err),
        .parity_err (parity_err)
    );

    initial clk_50m = 1'b0;
    always #10 clk_50m = ~clk_50m;

    // Oversampling enable: one cycle high out of every four
    initial begin
        rxclk_en = 1'b0;
        tick_cnt = 0;
        forever begin
            @(negedge clk_50m);
            tick_cnt = (tick_cnt + 1) % 4;
            rxclk_en = (tick_cnt == 0);
        end
    end

    typedef struct {
        logic [7:0] tx;
        logic       clr_before;
        logic [7:0] exp_data;
        logic       exp_rdy;
        logic       exp_ovr;
        logic       exp_fe;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk_50m);
    endtask

    task automatic pulse_clr();
        @(negedge clk_50m);
        rdy_clr = 1'b1;
        @(negedge clk_50m);
        rdy_clr = 1'b0;
    endtask

    // Start bit, data LSB first, optional even parity (inverted when
    // flip_par is set), then the given stop level. Leaves rx at stop level.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic flip_par);
        rx = 1'b0;
        wait_cycles(c_BIT_CYC);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_cycles(c_BIT_CYC);
        end
`ifdef UART_RX_PARITY_EN
        rx = (^b) ^ flip_par;
        wait_cycles(c_BIT_CYC);
`else
        if (flip_par) rx = 1'b0;
`endif
        rx = stop_bit;
        wait_cycles(c_BIT_CYC);
    endtask

    task automatic idle_bits(input int n);
        rx = 1'b1;
        wait_cycles(n * c_BIT_CYC);
    endtask

    initial begin
        int   lat;
        logic saw_rdy;

        n_checks = 0;
        n_errors = 0;
        reset_n  = 1'b0;
        rx       = 1'b1;
        rdy_clr  = 1'b0;

        vecs[0] = '{tx: 8'h3C, clr_before: 1'b1, exp_data: 8'h3C, exp_rdy: 1'b1, exp_ovr: 1'b0, exp_fe: 1'b0};
        vecs[1] = '{tx: 8'h7E, clr_before: 1'b0, exp_data: 8'h7E, exp_rdy: 1'b1, exp_ovr: 1'b1, exp_fe: 1'b0};
        vecs[2] = '{tx: 8'h00, clr_before: 1'b1, exp_data: 8'h00, exp_rdy: 1'b1, exp_ovr: 1'b0, exp_fe: 1'b0};
        vecs[3] = '{tx: 8'hFF, clr_before: 1'b1, exp_data: 8'hFF, exp_rdy: 1'b1, exp_ovr: 1'b0, exp_fe: 1'b0};
        vecs[4] = '{tx: 8'h96, clr_before: 1'b0, exp_data: 8'h96, exp_rdy: 1'b1, exp_ovr: 1'b1, exp_fe: 1'b0};

        // ---------------- reset state ----------------
        wait_cycles(5);
        check("reset_data", 32'(data), 32'h00);
        check("reset_flags", {28'd0, rdy, overrun, frame_err, parity_err}, 32'h0);
        @(negedge clk_50m);
        reset_n = 1'b1;
        idle_bits(1);

        // ---------------- 0xA5 with latency ----------------
        lat = -1;
        fork
            send_frame(8'hA5, 1'b1, 1'b0);
            begin
                for (int i = 0; i < 800; i++) begin
                    @(negedge clk_50m);
                    if (rdy && lat < 0) lat = i + 1;
                end
            end
        join
        idle_bits(1);
        n_checks++;
        if (lat < c_LAT_MIN || lat > c_LAT_MAX) begin
            n_errors++;
            $display("FAIL latency: got %0d cycles, expected %0d..%0d", lat, c_LAT_MIN, c_LAT_MAX);
        end
        check("a5_data", 32'(data), 32'hA5);
        check("a5_flags", {29'd0, rdy, overrun, frame_err}, 32'b100);

        // ---------------- table-driven frames ----------------
        for (int v = 0; v < 5; v++) begin
            if (vecs[v].clr_before) pulse_clr();
            send_frame(vecs[v].tx, 1'b1, 1'b0);
            idle_bits(1);
            check($sformatf("vec%0d_data", v), 32'(data), 32'(vecs[v].exp_data));
            check($sformatf("vec%0d_rdy", v), 32'(rdy), 32'(vecs[v].exp_rdy));
            check($sformatf("vec%0d_ovr", v), 32'(overrun), 32'(vecs[v].exp_ovr));
            check($sformatf("vec%0d_fe", v), 32'(frame_err), 32'(vecs[v].exp_fe));
        end
        pulse_clr();
        check("clr_flags", {29'd0, rdy, overrun, frame_err}, 32'b000);
        check("clr_data_kept", 32'(data), 32'h96);

        // ---------------- start glitch ----------------
        rx = 1'b0;
        wait_cycles(12);
        idle_bits(2);
        check("glitch_flags", {29'd0, rdy, overrun, frame_err}, 32'b000);
        check("glitch_data", 32'(data), 32'h96);
        send_frame(8'h0F, 1'b1, 1'b0);
        idle_bits(1);
        check("post_glitch_data", 32'(data), 32'h0F);
        check("post_glitch_rdy", 32'(rdy), 32'h1);
        pulse_clr();

        // ---------------- break: stop low for 20 bits ----------------
        send_frame(8'h55, 1'b0, 1'b0);
        rx = 1'b0;
        wait_cycles(19 * c_BIT_CYC);
        idle_bits(2);
        check("break_fe", 32'(frame_err), 32'h1);
        check("break_rdy", 32'(rdy), 32'h0);
        check("break_data", 32'(data), 32'h0F);
        send_frame(8'h12, 1'b1, 1'b0);
        idle_bits(1);
        check("after_break_data", 32'(data), 32'h12);
        check("after_break_flags", {29'd0, rdy, overrun, frame_err}, 32'b101);

        // ---------------- reset mid data bit 4 of 0xFF ----------------
        fork
            send_frame(8'hFF, 1'b1, 1'b0);
            begin
                wait_cycles(5 * c_BIT_CYC + c_BIT_CYC / 2);
                reset_n = 1'b0;
                #1;
                check("midreset_data", 32'(data), 32'h00);
                check("midreset_flags", {28'd0, rdy, overrun, frame_err, parity_err}, 32'h0);
                wait_cycles(10);
                reset_n = 1'b1;
            end
        join
        idle_bits(1);
        check("after_reset_flags", {29'd0, rdy, overrun, frame_err}, 32'b000);
        send_frame(8'h81, 1'b1, 1'b0);
        idle_bits(1);
        check("post_reset_data", 32'(data), 32'h81);
        check("post_reset_flags", {29'd0, rdy, overrun, frame_err}, 32'b100);
        pulse_clr();

        // ---------------- set beats a simultaneous clear ----------------
        saw_rdy = 1'b0;
        @(negedge clk_50m);
        rdy_clr = 1'b1;
        fork
            send_frame(8'hC3, 1'b1, 1'b0);
            begin
                for (int i = 0; i < 800; i++) begin
                    @(negedge clk_50m);
                    if (rdy) saw_rdy = 1'b1;
                end
            end
        join
        rdy_clr = 1'b0;
        idle_bits(1);
        check("set_wins_seen", 32'(saw_rdy), 32'h1);
        check("set_wins_data", 32'(data), 32'hC3);
        check("set_wins_cleared", 32'(rdy), 32'h0);

`ifdef UART_RX_PARITY_EN
        // ---------------- parity ----------------
        send_frame(8'h07, 1'b1, 1'b0);
        idle_bits(1);
        check("par_good_pe", 32'(parity_err), 32'h0);
        check("par_good_rdy", 32'(rdy), 32'h1);
        check("par_good_data", 32'(data), 32'h07);
        pulse_clr();
        send_frame(8'h07, 1'b1, 1'b1);
        idle_bits(1);
        check("par_bad_pe", 32'(parity_err), 32'h1);
        check("par_bad_rdy", 32'(rdy), 32'h1);
        check("par_bad_data", 32'(data), 32'h07);
`else
        check("parity_err_tied", 32'(parity_err), 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
